// File: rtl/bb_rz_frame_scheduler.sv
// Frame sequencer for the baseband RZ pulse path: it emits an alternating preamble,
// then MSB-first data symbols, then an inter-frame gap. Each symbol is one RZ window.
module bb_rz_frame_scheduler #(
  parameter int SYM_CYCLES   = 20,
  parameter int BASE_HIGH    = 2,
  parameter int PREAMBLE_LEN = 4,
  parameter int GAP_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cfg_pw1,
  input  logic [1:0] cfg_pw0,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       pulse_out,
  output logic       sym_bit,
  output logic       sym_strobe,
  output logic       busy,
  output logic       frame_done,
  output logic       err_underrun
);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_GAP} state_t;

  localparam logic [7:0] SYM_LAST = 8'(SYM_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);
  localparam logic [7:0] BASE_HI  = 8'(BASE_HIGH);

  state_t     r_state, w_next;
  logic [7:0] r_sym_cnt, r_gap_cnt, r_hold, r_shift;
  logic [3:0] r_pre_idx;
  logic [2:0] r_bit_idx;
  logic [1:0] r_pw1, r_pw0;
  logic       r_hold_full, r_last_seen, r_err;

  logic       w_hs, w_sym_last, w_pre_end, w_gap_last;
  logic       w_active, w_sym_bit, w_load_hold, w_bypass, w_underrun;
  logic [1:0] w_pw;
  logic [7:0] w_high;

  assign in_ready   = ~r_hold_full & ~r_last_seen & (r_state != S_GAP);
  assign w_hs       = in_valid & in_ready;
  assign w_sym_last = (r_sym_cnt == SYM_LAST);
  assign w_pre_end  = (r_state == S_PREAMBLE) && w_sym_last && (r_pre_idx == PRE_LAST);
  assign w_gap_last = (r_state == S_GAP) && (r_gap_cnt == GAP_LAST);

  // NOTE: the state register uses a synchronous reset, so rst only acts on a clock edge.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every signal driven here gets a default first so no latch can be inferred.
  always_comb begin
    w_next      = r_state;
    w_active    = 1'b0;
    w_sym_bit   = 1'b0;
    w_load_hold = 1'b0;
    w_bypass    = 1'b0;
    w_underrun  = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_hs) w_next = S_PREAMBLE;
      S_PREAMBLE: begin
        w_active  = 1'b1;
        w_sym_bit = ~r_pre_idx[0];
        if (w_pre_end) w_next = S_DATA;
      end
      S_DATA: begin
        w_active  = 1'b1;
        w_sym_bit = r_shift[r_bit_idx];
        // A full hold register never holds the current byte, so the last-byte test
        // reduces to last_seen with an empty hold register.
        if (w_sym_last && r_bit_idx == 3'd0) begin
          if (r_hold_full)                 w_load_hold = 1'b1;
          else if (!r_last_seen && w_hs)   w_bypass    = 1'b1;
          else begin
            w_next     = S_GAP;
            w_underrun = ~r_last_seen;
          end
        end
      end
      S_GAP: if (w_gap_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sym_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_pre_idx   <= '0;
      r_bit_idx   <= '0;
      r_hold      <= '0;
      r_shift     <= '0;
      r_hold_full <= 1'b0;
      r_last_seen <= 1'b0;
      r_pw1       <= '0;
      r_pw0       <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_active) r_sym_cnt <= w_sym_last ? 8'd0 : r_sym_cnt + 8'd1;
      if (r_state == S_PREAMBLE && w_sym_last)
        r_pre_idx <= w_pre_end ? 4'd0 : r_pre_idx + 4'd1;
      if (w_pre_end)                              r_bit_idx <= 3'd7;
      else if (r_state == S_DATA && w_sym_last)   r_bit_idx <= r_bit_idx - 3'd1;
      if (r_state == S_GAP) r_gap_cnt <= w_gap_last ? 8'd0 : r_gap_cnt + 8'd1;

      if (w_pre_end || w_load_hold) r_shift <= r_hold;
      else if (w_bypass)            r_shift <= in_data;

      if (w_gap_last || w_pre_end || w_load_hold) r_hold_full <= 1'b0;
      else if (w_hs && !w_bypass)                 r_hold_full <= 1'b1;
      if (w_hs && !w_bypass) r_hold <= in_data;

      if (w_gap_last)             r_last_seen <= 1'b0;
      else if (w_hs && in_last)   r_last_seen <= 1'b1;

      if (r_state == S_IDLE && w_hs) begin
        r_pw1 <= cfg_pw1;
        r_pw0 <= cfg_pw0;
        r_err <= 1'b0;
      end else if (w_underrun) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_pw         = w_sym_bit ? r_pw1 : r_pw0;
  assign w_high       = BASE_HI + {6'd0, w_pw};
  assign pulse_out    = w_active && (r_sym_cnt < w_high);
  assign sym_bit      = w_sym_bit;
  assign sym_strobe   = w_active && (r_sym_cnt == 8'd0);
  assign busy         = (r_state != S_IDLE);
  assign frame_done   = w_gap_last;
  assign err_underrun = r_err;

endmodule

// File: tb/tb_bb_rz_frame_scheduler.sv
// Bench for bb_rz_frame_scheduler: a frame-level model expands each frame into an
// expected per-cycle stream; directed scenarios add hand-computed spot checks.
module tb_bb_rz_frame_scheduler;

  localparam int SYM  = 20;
  localparam int BASE = 2;
  localparam int PRE  = 4;
  localparam int GAP  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cfg_pw1 = 2'd0, cfg_pw0 = 2'd0;
  logic       in_valid = 1'b0, in_last = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready, pulse_out, sym_bit, sym_strobe, busy, frame_done, err_underrun;

  bb_rz_frame_scheduler #(
    .SYM_CYCLES(SYM), .BASE_HIGH(BASE), .PREAMBLE_LEN(PRE), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .cfg_pw1(cfg_pw1), .cfg_pw0(cfg_pw0),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .pulse_out(pulse_out), .sym_bit(sym_bit), .sym_strobe(sym_strobe), .busy(busy),
    .frame_done(frame_done), .err_underrun(err_underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic sym;
    logic pulse;
    logic strobe;
    logic bit_v;
    logic busy;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   t0 = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Expand one frame into its per-cycle expectation: preamble bits, data bits MSB first,
  // one window per bit with high time BASE + pw(bit), then the gap.
  task automatic model_frame(input logic [1:0] pw1, input logic [1:0] pw0,
                             input logic [15:0] data, input int nbytes);
    logic bits[$];
    exp_t e;
    int   width;
    for (int i = 0; i < PRE; i++) bits.push_back((i % 2) == 0);
    for (int b = 0; b < nbytes; b++)
      for (int k = 7; k >= 0; k--) bits.push_back(data[8 * (1 - b) + k]);
    foreach (bits[s]) begin
      width = BASE + (bits[s] ? int'(pw1) : int'(pw0));
      for (int c = 0; c < SYM; c++) begin
        e = '{sym: 1'b1, pulse: (c < width), strobe: (c == 0), bit_v: bits[s],
              busy: 1'b1, done: 1'b0};
        exp_q.push_back(e);
      end
    end
    for (int g = 0; g < GAP; g++) begin
      e = '{sym: 1'b0, pulse: 1'b0, strobe: 1'b0, bit_v: 1'b0, busy: 1'b1,
            done: (g == GAP - 1)};
      exp_q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (chk_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stream pulse_out", 32'(pulse_out), 32'(e.pulse));
        check("stream sym_strobe", 32'(sym_strobe), 32'(e.strobe));
        check("stream busy", 32'(busy), 32'(e.busy));
        check("stream frame_done", 32'(frame_done), 32'(e.done));
        if (e.sym) check("stream sym_bit", 32'(sym_bit), 32'(e.bit_v));
      end else begin
        check("idle busy", 32'(busy), 32'd0);
        check("idle pulse_out", 32'(pulse_out), 32'd0);
        check("idle frame_done", 32'(frame_done), 32'd0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_to(input int off);
    while (cyc - t0 < off) @(negedge clk);
  endtask

  // Present one byte in IDLE for a single cycle and register the frame with the model.
  task automatic start_frame(input logic [1:0] pw1, input logic [1:0] pw0,
                             input logic [7:0] b, input logic last,
                             input logic [15:0] model_data, input int nbytes);
    cfg_pw1  = pw1;
    cfg_pw0  = pw0;
    in_data  = b;
    in_last  = last;
    in_valid = 1'b1;
    check("in_ready before frame", 32'(in_ready), 32'd1);
    model_frame(pw1, pw0, model_data, nbytes);
    t0 = cyc;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("reset pulse_out", 32'(pulse_out), 32'd0);
    check("reset sym_bit", 32'(sym_bit), 32'd0);
    check("reset sym_strobe", 32'(sym_strobe), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset err_underrun", 32'(err_underrun), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();
    check("in_ready after reset", 32'(in_ready), 32'd1);

    // Single-byte frame 0xA5, pw1=1 (width 3), pw0=3 (width 5).
    tick();
    start_frame(2'd1, 2'd3, 8'hA5, 1'b1, 16'hA500, 1);
    check("single T+1 strobe", 32'(sym_strobe), 32'd1);
    check("single T+1 busy", 32'(busy), 32'd1);
    wait_to(3);  check("single pre0 c2 high", 32'(pulse_out), 32'd1);
    wait_to(4);  check("single pre0 c3 low", 32'(pulse_out), 32'd0);
    wait_to(25); check("single pre1 c4 high", 32'(pulse_out), 32'd1);
    wait_to(26); check("single pre1 c5 low", 32'(pulse_out), 32'd0);
    wait_to(248); check("single frame_done T+248", 32'(frame_done), 32'd1);
    wait_to(249); check("single busy low T+249", 32'(busy), 32'd0);
    check("single in_ready T+249", 32'(in_ready), 32'd1);

    // Two-byte frame 0xFF, 0x00(last); second byte offered during the preamble.
    tick();
    start_frame(2'd1, 2'd3, 8'hFF, 1'b0, 16'hFF00, 2);
    check("two in_ready drops", 32'(in_ready), 32'd0);
    in_data  = 8'h00;
    in_last  = 1'b1;
    in_valid = 1'b1;
    begin
      int waited = 0;
      while (!in_ready && waited < 200) begin
        tick();
        waited++;
      end
      check("two in_ready rise offset", 32'(cyc - t0), 32'd81);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("two in_ready drops again", 32'(in_ready), 32'd0);
    wait_to(408); check("two frame_done T+408", 32'(frame_done), 32'd1);
    wait_to(409); check("two busy low", 32'(busy), 32'd0);

    // Bypass: byte 2 appears only on the last cycle of byte 1's bit-0 symbol.
    tick();
    start_frame(2'd1, 2'd3, 8'h96, 1'b0, 16'h963C, 2);
    wait_to(240);
    check("bypass in_ready at boundary", 32'(in_ready), 32'd1);
    in_data  = 8'h3C;
    in_last  = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("bypass no underrun", 32'(err_underrun), 32'd0);
    check("bypass bit7 strobe", 32'(sym_strobe), 32'd1);
    check("bypass bit7 value", 32'(sym_bit), 32'd0);
    wait_to(408); check("bypass frame_done", 32'(frame_done), 32'd1);
    wait_to(409);

    // Underrun: one byte without last and nothing after it.
    tick();
    start_frame(2'd1, 2'd3, 8'h3C, 1'b0, 16'h3C00, 1);
    wait_to(240); check("underrun not yet", 32'(err_underrun), 32'd0);
    wait_to(241); check("underrun set", 32'(err_underrun), 32'd1);
    wait_to(248); check("underrun frame_done", 32'(frame_done), 32'd1);
    wait_to(260); check("underrun sticky in idle", 32'(err_underrun), 32'd1);

    // Config latching: pw1 changes 0 -> 3 mid-frame, takes effect next frame.
    start_frame(2'd0, 2'd3, 8'hFF, 1'b1, 16'hFF00, 1);
    check("underrun cleared by handshake", 32'(err_underrun), 32'd0);
    wait_to(2); check("cfg pw1=0 c1 high", 32'(pulse_out), 32'd1);
    wait_to(3); check("cfg pw1=0 c2 low", 32'(pulse_out), 32'd0);
    wait_to(50);
    cfg_pw1 = 2'd3;
    wait_to(83); check("cfg data c2 still low", 32'(pulse_out), 32'd0);
    wait_to(249);
    tick();
    start_frame(2'd3, 2'd3, 8'hF0, 1'b1, 16'hF000, 1);
    wait_to(5); check("cfg pw1=3 c4 high", 32'(pulse_out), 32'd1);
    wait_to(6); check("cfg pw1=3 c5 low", 32'(pulse_out), 32'd0);
    wait_to(249);

    // Reset mid-DATA, then a clean frame.
    tick();
    start_frame(2'd1, 2'd3, 8'h5A, 1'b1, 16'h5A00, 1);
    wait_to(100);
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("rst pulse_out", 32'(pulse_out), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    tick();
    check("rst in_ready after", 32'(in_ready), 32'd1);
    start_frame(2'd1, 2'd3, 8'hA5, 1'b1, 16'hA500, 1);
    wait_to(3);  check("post-rst pre0 c2 high", 32'(pulse_out), 32'd1);
    wait_to(4);  check("post-rst pre0 c3 low", 32'(pulse_out), 32'd0);
    wait_to(25); check("post-rst pre1 c4 high", 32'(pulse_out), 32'd1);
    wait_to(26); check("post-rst pre1 c5 low", 32'(pulse_out), 32'd0);
    wait_to(248); check("post-rst frame_done", 32'(frame_done), 32'd1);
    wait_to(251);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
